// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: control codes, ALUOp/funct encodings,
// multiplier FSM states and a magnitude helper.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_MUL     = 4'b1000;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Signed 32x32 shift-add multiplier, one partial product per clock, 64-bit result.
// The FSM state is exported on the state port for observation.
module seq_multiplier
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output mul_state_e  state,
  output logic [63:0] product,
  output logic        done
);

  // Handshake: start is a level request held for the whole operation. Dropping it
  // in BUSY aborts; in DONE the result stays until start drops or a/b change.
  mul_state_e  state_next;
  logic [31:0] a_lat, b_lat, mplier;
  logic [63:0] acc, mcand, step_sum;
  logic [4:0]  count;
  logic        neg;

  always_comb begin
    state_next = state;
    case (state)
      MUL_IDLE: if (start) state_next = MUL_BUSY;
      MUL_BUSY: begin
        if (!start)                state_next = MUL_IDLE;
        else if (count == 5'd31)   state_next = MUL_DONE;
      end
      MUL_DONE: if (!start || a != a_lat || b != b_lat) state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  assign step_sum = acc + (mplier[0] ? mcand : 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      acc    <= 64'd0;
      count  <= 5'd0;
      a_lat  <= 32'd0;
      b_lat  <= 32'd0;
      mcand  <= 64'd0;
      mplier <= 32'd0;
      neg    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        MUL_IDLE: if (start) begin
          a_lat  <= a;
          b_lat  <= b;
          mcand  <= {32'd0, abs32(a)};
          mplier <= abs32(b);
          neg    <= a[31] ^ b[31];
          acc    <= 64'd0;
          count  <= 5'd0;
        end
        MUL_BUSY: if (start) begin
          // The last step folds the sign back in so DONE holds the final product.
          acc    <= (count == 5'd31 && neg) ? -step_sum : step_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = acc;
  assign done    = (state == MUL_DONE);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, 32-bit ALU with zero/overflow, branch-target adder.
// Define ALU_MUL_EN to include the sequential signed multiplier (funct 011000).
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ALUOp,
  input  logic [5:0]  function_code,
  input  logic [31:0] read_data1,
  input  logic [31:0] data2,
  input  logic [31:0] PC_in,
  input  logic [31:0] offset,
  output logic [3:0]  ALUControl,
  output logic [31:0] ALU_out,
  output logic        Zero,
  output logic        overflow,
  output logic        mul_busy,
  output logic [31:0] PC_out
);

  logic [31:0] sum, diff;

  always_comb begin
    ALUControl = ALU_INVALID;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_SLT: ALUControl = ALU_SLT;
      default: begin
        case (function_code)
          FUNCT_ADD: ALUControl = ALU_ADD;
          FUNCT_SUB: ALUControl = ALU_SUB;
          FUNCT_AND: ALUControl = ALU_AND;
          FUNCT_OR:  ALUControl = ALU_OR;
          FUNCT_NOR: ALUControl = ALU_NOR;
          FUNCT_SLT: ALUControl = ALU_SLT;
`ifdef ALU_MUL_EN
          FUNCT_MUL: ALUControl = ALU_MUL;
`endif
          default:   ALUControl = ALU_INVALID;
        endcase
      end
    endcase
  end

`ifdef ALU_MUL_EN
  mul_state_e  mul_state;
  logic [63:0] mul_product;
  logic        mul_done;

  seq_multiplier u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (ALUControl == ALU_MUL),
    .a       (read_data1),
    .b       (data2),
    .state   (mul_state),
    .product (mul_product),
    .done    (mul_done)
  );

  assign mul_busy = (mul_state == MUL_BUSY) ||
                    (mul_state == MUL_IDLE && ALUControl == ALU_MUL);
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign mul_busy = 1'b0;
`endif

  assign sum  = read_data1 + data2;
  assign diff = read_data1 - data2;

  always_comb begin
    ALU_out  = 32'd0;
    overflow = 1'b0;
    case (ALUControl)
      ALU_ADD: begin
        ALU_out  = sum;
        overflow = (read_data1[31] == data2[31]) && (sum[31] != read_data1[31]);
      end
      ALU_SUB: begin
        ALU_out  = diff;
        overflow = (read_data1[31] != data2[31]) && (diff[31] != read_data1[31]);
      end
      ALU_AND: ALU_out = read_data1 & data2;
      ALU_OR:  ALU_out = read_data1 | data2;
      ALU_NOR: ALU_out = ~(read_data1 | data2);
      ALU_SLT: ALU_out = {31'd0, $signed(read_data1) < $signed(data2)};
`ifdef ALU_MUL_EN
      ALU_MUL: if (mul_done) begin
        ALU_out  = mul_product[31:0];
        overflow = mul_product[63:32] != {32{mul_product[31]}};
      end
`endif
      default: ;
    endcase
  end

  assign Zero   = (ALU_out == 32'd0) && !mul_busy;
  assign PC_out = PC_in + (offset << 2);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected outputs queued per cycle, checked by a
// negedge monitor. Multiplier sequences run only when ALU_MUL_EN is defined.
module tb_alu_exec_unit;

  localparam int W = 71;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ALUOp;
  logic [5:0]  function_code;
  logic [31:0] read_data1, data2, PC_in, offset;
  logic [3:0]  ALUControl;
  logic [31:0] ALU_out, PC_out;
  logic        Zero, overflow, mul_busy;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           errors = 0;
  int           checks = 0;
  logic         chk = 1'b0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk           (clk),
    .rst           (rst),
    .ALUOp         (ALUOp),
    .function_code (function_code),
    .read_data1    (read_data1),
    .data2         (data2),
    .PC_in         (PC_in),
    .offset        (offset),
    .ALUControl    (ALUControl),
    .ALU_out       (ALU_out),
    .Zero          (Zero),
    .overflow      (overflow),
    .mul_busy      (mul_busy),
    .PC_out        (PC_out)
  );

  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string nm;
    if (chk) begin
      got = {ALUControl, ALU_out, Zero, overflow, mul_busy, PC_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: got %h, required an expected entry", got);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL %s: got ctrl=%h out=%h z=%b ov=%b busy=%b pc=%h, required ctrl=%h out=%h z=%b ov=%b busy=%b pc=%h",
                   nm, got[70:67], got[66:35], got[34], got[33], got[32], got[31:0],
                   exp[70:67], exp[66:35], exp[34], exp[33], exp[32], exp[31:0]);
        end
      end
    end
  end

  task automatic drive(input string nm, input logic r, input logic [1:0] op,
                       input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] off,
                       input logic [3:0] e_ctrl, input logic [31:0] e_out,
                       input logic e_ov, input logic e_busy, input logic [31:0] e_pc);
    logic e_zero;
    @(posedge clk);
    #1;
    rst = r; ALUOp = op; function_code = fn;
    read_data1 = a; data2 = b; PC_in = pc; offset = off;
    e_zero = (e_out == 32'd0) && !e_busy;
    exp_q.push_back({e_ctrl, e_out, e_zero, e_ov, e_busy, e_pc});
    name_q.push_back(nm);
    chk = 1'b1;
  endtask

  task automatic mul_run(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_out, input logic e_ov);
    for (int k = 0; k < 33; k++)
      drive({nm, "_busy"}, 1'b0, 2'b10, 6'b011000, a, b, 32'd0, 32'd0,
            4'b1000, 32'd0, 1'b0, 1'b1, 32'd0);
    drive({nm, "_res"}, 1'b0, 2'b10, 6'b011000, a, b, 32'd0, 32'd0,
          4'b1000, e_out, e_ov, 1'b0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ALUOp = 2'b00; function_code = 6'd0;
    read_data1 = 32'd0; data2 = 32'd0; PC_in = 32'd0; offset = 32'd0;

    drive("reset0", 1'b1, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0010, 32'd0, 1'b0, 1'b0, 32'd0);
    drive("reset1", 1'b1, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0010, 32'd0, 1'b0, 1'b0, 32'd0);

    drive("add_ovf",   1'b0, 2'b10, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 32'd0, 32'd0, 4'b0010, 32'h80000000, 1'b1, 1'b0, 32'd0);
    drive("sub_zero",  1'b0, 2'b01, 6'd0,      32'd5,        32'd5,        32'd0, 32'd0, 4'b0110, 32'd0,        1'b0, 1'b0, 32'd0);
    drive("slt_neg",   1'b0, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 32'd0, 32'd0, 4'b0111, 32'd1,        1'b0, 1'b0, 32'd0);
    drive("invalid",   1'b0, 2'b10, 6'b111111, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0, 4'b1111, 32'd0,        1'b0, 1'b0, 32'd0);
    drive("pc_back",   1'b0, 2'b00, 6'd0,      32'd3,        32'd4,        32'h00400004, 32'hFFFFFFFF, 4'b0010, 32'd7, 1'b0, 1'b0, 32'h00400000);
    drive("pc_wrap",   1'b0, 2'b00, 6'd0,      32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFC, 32'h00000001, 4'b0010, 32'd0, 1'b0, 1'b0, 32'h00000000);
    drive("sub_ovf",   1'b0, 2'b10, 6'b100010, 32'h80000000, 32'h00000001, 32'd0, 32'd0, 4'b0110, 32'h7FFFFFFF, 1'b1, 1'b0, 32'd0);
    drive("and",       1'b0, 2'b10, 6'b100100, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 32'd0, 4'b0000, 32'h00F0000F, 1'b0, 1'b0, 32'd0);
    drive("or",        1'b0, 2'b10, 6'b100101, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 32'd0, 4'b0001, 32'hFFF00FFF, 1'b0, 1'b0, 32'd0);
    drive("nor",       1'b0, 2'b10, 6'b100111, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 32'd0, 4'b1100, 32'h000FF000, 1'b0, 1'b0, 32'd0);
    drive("slt_op11",  1'b0, 2'b11, 6'd0,      32'd5,        32'hFFFFFFFE, 32'd0, 32'd0, 4'b0111, 32'd0,        1'b0, 1'b0, 32'd0);
    drive("sub_ovf2",  1'b0, 2'b01, 6'd0,      32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 4'b0110, 32'h80000000, 1'b1, 1'b0, 32'd0);
    drive("slt_ext",   1'b0, 2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0, 4'b0111, 32'd1,        1'b0, 1'b0, 32'd0);
    drive("add_negov", 1'b0, 2'b10, 6'b100000, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 4'b0010, 32'd0,        1'b1, 1'b0, 32'd0);

`ifdef ALU_MUL_EN
    mul_run("mul_m3x7", 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0);
    drive("gap0", 1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0010, 32'd0, 1'b0, 1'b0, 32'd0);
    mul_run("mul_ovf", 32'h00010000, 32'h00010000, 32'd0, 1'b1);
    drive("gap1", 1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0010, 32'd0, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 12; k++)
      drive("mul_abort_busy", (k == 11), 2'b10, 6'b011000, 32'd100, 32'd100, 32'd0, 32'd0,
            4'b1000, 32'd0, 1'b0, 1'b1, 32'd0);
    mul_run("mul_restart", 32'd6, 32'd7, 32'd42, 1'b0);
`else
    drive("mul_off", 1'b0, 2'b10, 6'b011000, 32'd6, 32'd7, 32'd0, 32'd0, 4'b1111, 32'd0, 1'b0, 1'b0, 32'd0);
    drive("mul_off2", 1'b0, 2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7, 32'h00001000, 32'd2, 4'b1111, 32'd0, 1'b0, 1'b0, 32'h00001008);
`endif

    @(posedge clk);
    #1;
    chk = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
